// File: rtl/ahb_dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_dm_arbiter_if
// Brief    : One AHB-Lite link. Two views: the arbiter as subordinate to a
//            manager (slave) and as manager of the data memory (master).
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_dm_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;

  // Arbiter drives the memory; HREADY is the looped-back HREADYOUT
  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface
`default_nettype wire

// File: rtl/ahb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_dm_arbiter
// Brief    : Two-manager AHB-Lite arbiter in front of a single data memory.
//            Define ARB_ROUND_ROBIN_EN for round-robin on contested switch
//            points; otherwise M0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_dm_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_dm_arbiter_if.slave  m0,
  ahb_dm_arbiter_if.slave  m1,
  ahb_dm_arbiter_if.master s,
  output logic             arb_owner
);

  localparam logic [1:0] c_IDLE   = 2'b00;
  localparam logic [1:0] c_BUSY   = 2'b01;
  localparam logic [1:0] c_NONSEQ = 2'b10;
  localparam logic [1:0] c_SEQ    = 2'b11;

  logic r_addr_owner;
  logic r_data_owner;
  logic r_data_active;

  logic [1:0] w_own_trans;
  logic       w_req0;
  logic       w_req1;
  logic       w_other_req;
  logic       w_own_locked;
  logic       w_next_owner;
  logic       w_m0_served;
  logic       w_m1_served;

  // Address-phase controls follow the address owner
  assign w_own_trans = r_addr_owner ? m1.HTRANS : m0.HTRANS;

  assign s.HADDR  = r_addr_owner ? m1.HADDR  : m0.HADDR;
  assign s.HWRITE = r_addr_owner ? m1.HWRITE : m0.HWRITE;
  assign s.HSIZE  = r_addr_owner ? m1.HSIZE  : m0.HSIZE;
  assign s.HTRANS = HRESETn ? w_own_trans : c_IDLE;
  assign s.HWDATA = r_data_owner ? m1.HWDATA : m0.HWDATA;
  assign s.HREADY = s.HREADYOUT;

  assign m0.HRDATA = s.HRDATA;
  assign m1.HRDATA = s.HRDATA;

  assign arb_owner = HRESETn & r_addr_owner;

  // A manager is served while it owns the address phase or the live data phase
  assign w_m0_served = !r_addr_owner || (!r_data_owner && r_data_active);
  assign w_m1_served =  r_addr_owner || ( r_data_owner && r_data_active);

  assign m0.HREADY = !HRESETn     ? 1'b1 :
                     w_m0_served  ? s.HREADYOUT : !m0.HTRANS[1];
  assign m1.HREADY = !HRESETn     ? 1'b1 :
                     w_m1_served  ? s.HREADYOUT : !m1.HTRANS[1];

  assign m0.HRESP = HRESETn && !r_data_owner && r_data_active && s.HRESP;
  assign m1.HRESP = HRESETn &&  r_data_owner && r_data_active && s.HRESP;

  assign w_req0       = (m0.HTRANS == c_NONSEQ) &&  r_addr_owner;
  assign w_req1       = (m1.HTRANS == c_NONSEQ) && !r_addr_owner;
  assign w_other_req  = r_addr_owner ? w_req0 : w_req1;
  assign w_own_locked = (w_own_trans == c_SEQ) || (w_own_trans == c_BUSY);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_ptr;
  logic w_last_owner;

  // The transfer issued this cycle counts as the most recent one
  assign w_last_owner = w_own_trans[1] ? r_addr_owner : r_rr_ptr;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rr_ptr <= 1'b0;
    end else if (s.HREADYOUT && w_own_trans[1]) begin
      r_rr_ptr <= r_addr_owner;
    end
  end
`endif

  always_comb begin
    w_next_owner = r_addr_owner;
    if (!w_own_locked && w_other_req) begin
      if (w_own_trans == c_NONSEQ) begin
`ifdef ARB_ROUND_ROBIN_EN
        w_next_owner = ~w_last_owner;
`else
        w_next_owner = 1'b0;
`endif
      end else begin
        w_next_owner = ~r_addr_owner;
      end
    end
  end

  // All state freezes while the memory stalls, including ERROR cycle one
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_addr_owner  <= 1'b0;
      r_data_owner  <= 1'b0;
      r_data_active <= 1'b0;
    end else if (s.HREADYOUT) begin
      r_data_owner  <= r_addr_owner;
      r_data_active <= w_own_trans[1];
      r_addr_owner  <= w_next_owner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_dm_arbiter
// Brief    : Directed vector table plus hand sequences for ahb_dm_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_dm_arbiter;

  localparam int ADDR_W = 32;
  localparam logic [1:0] c_I = 2'b00;
  localparam logic [1:0] c_B = 2'b01;
  localparam logic [1:0] c_N = 2'b10;
  localparam logic [1:0] c_S = 2'b11;
  localparam logic [31:0] c_WD0 = 32'h0000_AAAA;
  localparam logic [31:0] c_WD1 = 32'h0000_BBBB;
  localparam int NV = 19;

  logic HCLK;
  logic HRESETn;
  logic arb_owner;

  ahb_dm_arbiter_if #(.ADDR_W(ADDR_W)) m0 ();
  ahb_dm_arbiter_if #(.ADDR_W(ADDR_W)) m1 ();
  ahb_dm_arbiter_if #(.ADDR_W(ADDR_W)) s ();

  ahb_dm_arbiter #(.ADDR_W(ADDR_W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .m0        (m0),
    .m1        (m1),
    .s         (s),
    .arb_owner (arb_owner)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Subordinate: zero-wait memory, or table-driven response
  logic        use_mem;
  logic        tv_rdy;
  logic        tv_resp;
  logic [31:0] tv_rdata;
  logic [31:0] mem [0:255];
  logic        dp_act;
  logic        dp_wr;
  logic [7:0]  dp_idx;

  assign s.HREADYOUT  = use_mem ? 1'b1 : tv_rdy;
  assign s.HRESP      = tv_resp;
  assign s.HRDATA     = use_mem ? mem[dp_idx] : tv_rdata;
  assign m0.HREADYOUT = 1'b1;
  assign m1.HREADYOUT = 1'b1;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_act <= 1'b0;
    end else if (s.HREADYOUT) begin
      if (dp_act && dp_wr) mem[dp_idx] <= s.HWDATA;
      dp_act <= s.HTRANS[1];
      dp_idx <= s.HADDR[9:2];
      dp_wr  <= s.HWRITE;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
    m0.HTRANS = t; m0.HADDR = a; m0.HWRITE = w; m0.HWDATA = d; m0.HSIZE = 3'b010;
  endtask

  task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
    m1.HTRANS = t; m1.HADDR = a; m1.HWRITE = w; m1.HWDATA = d; m1.HSIZE = 3'b010;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    tick();
    HRESETn = 1'b0;
    drv0(c_I, 32'h0, 1'b0, c_WD0);
    drv1(c_I, 32'h0, 1'b0, c_WD1);
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  typedef struct {
    logic        rstn;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        rdy;
    logic        resp;
    logic        e_own;
    logic [1:0]  e_st;
    logic [31:0] e_sa;
    logic        e_r0;
    logic        e_r1;
    logic        e_p0;
    logic        e_p1;
    logic        e_wd;
  } vec_t;

  vec_t vecs [0:NV-1];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst t0   a0         t1   a1         rdy rsp | own st   saddr      r0 r1 p0 p1 wd
    vecs[0]  = '{0, c_N, 32'h10,  c_N, 32'h200, 1, 0,  0, c_I, 32'h10,  1, 1, 0, 0, 0};
    vecs[1]  = '{1, c_I, 32'h10,  c_I, 32'h200, 1, 0,  0, c_I, 32'h10,  1, 1, 0, 0, 0};
    vecs[2]  = '{1, c_N, 32'h100, c_I, 32'h200, 1, 0,  0, c_N, 32'h100, 1, 1, 0, 0, 0};
    vecs[3]  = '{1, c_I, 32'h104, c_N, 32'h200, 1, 0,  0, c_I, 32'h104, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, c_I, 32'h104, c_N, 32'h200, 1, 0,  1, c_N, 32'h200, 1, 1, 0, 0, 0};
    vecs[5]  = '{1, c_N, 32'h20,  c_I, 32'h204, 0, 0,  1, c_I, 32'h204, 0, 0, 0, 0, 1};
    vecs[6]  = '{1, c_N, 32'h20,  c_I, 32'h204, 0, 0,  1, c_I, 32'h204, 0, 0, 0, 0, 1};
    vecs[7]  = '{1, c_N, 32'h20,  c_I, 32'h204, 1, 0,  1, c_I, 32'h204, 0, 1, 0, 0, 1};
    vecs[8]  = '{1, c_N, 32'h20,  c_I, 32'h204, 1, 0,  0, c_N, 32'h20,  1, 1, 0, 0, 1};
    vecs[9]  = '{1, c_S, 32'h24,  c_N, 32'h300, 1, 0,  0, c_S, 32'h24,  1, 0, 0, 0, 0};
    vecs[10] = '{1, c_B, 32'h28,  c_N, 32'h300, 1, 0,  0, c_B, 32'h28,  1, 0, 0, 0, 0};
    vecs[11] = '{1, c_S, 32'h28,  c_N, 32'h300, 1, 0,  0, c_S, 32'h28,  1, 0, 0, 0, 0};
    vecs[12] = '{1, c_S, 32'h2C,  c_N, 32'h300, 1, 0,  0, c_S, 32'h2C,  1, 0, 0, 0, 0};
    vecs[13] = '{1, c_I, 32'h30,  c_N, 32'h300, 1, 0,  0, c_I, 32'h30,  1, 0, 0, 0, 0};
    vecs[14] = '{1, c_I, 32'h30,  c_N, 32'h300, 1, 0,  1, c_N, 32'h300, 1, 1, 0, 0, 0};
    vecs[15] = '{1, c_N, 32'h40,  c_I, 32'h304, 0, 1,  1, c_I, 32'h304, 0, 0, 0, 1, 1};
    vecs[16] = '{1, c_N, 32'h40,  c_I, 32'h304, 1, 1,  1, c_I, 32'h304, 0, 1, 0, 1, 1};
    vecs[17] = '{1, c_N, 32'h40,  c_I, 32'h304, 1, 1,  0, c_N, 32'h40,  1, 1, 0, 0, 1};
    vecs[18] = '{1, c_I, 32'h44,  c_I, 32'h304, 1, 1,  0, c_I, 32'h44,  1, 1, 1, 0, 0};

    HRESETn  = 1'b0;
    use_mem  = 1'b0;
    tv_rdy   = 1'b1;
    tv_resp  = 1'b0;
    tv_rdata = 32'h0;
    drv0(c_I, 32'h0, 1'b0, c_WD0);
    drv1(c_I, 32'h0, 1'b0, c_WD1);

    // Vector table: cycle-by-cycle arbitration, stalls, bursts, ERROR
    do_reset();
    for (int i = 0; i < NV; i++) begin
      tick();
      HRESETn = vecs[i].rstn;
      tv_rdy  = vecs[i].rdy;
      tv_resp = vecs[i].resp;
      drv0(vecs[i].t0, vecs[i].a0, 1'b1, c_WD0);
      drv1(vecs[i].t1, vecs[i].a1, 1'b1, c_WD1);
      @(negedge HCLK);
      chk($sformatf("v%0d owner", i),  {31'd0, arb_owner},   {31'd0, vecs[i].e_own});
      chk($sformatf("v%0d strans", i), {30'd0, s.HTRANS},    {30'd0, vecs[i].e_st});
      chk($sformatf("v%0d saddr", i),  s.HADDR,              vecs[i].e_sa);
      chk($sformatf("v%0d rdy0", i),   {31'd0, m0.HREADY},   {31'd0, vecs[i].e_r0});
      chk($sformatf("v%0d rdy1", i),   {31'd0, m1.HREADY},   {31'd0, vecs[i].e_r1});
      chk($sformatf("v%0d resp0", i),  {31'd0, m0.HRESP},    {31'd0, vecs[i].e_p0});
      chk($sformatf("v%0d resp1", i),  {31'd0, m1.HRESP},    {31'd0, vecs[i].e_p1});
      chk($sformatf("v%0d swdata", i), s.HWDATA,             vecs[i].e_wd ? c_WD1 : c_WD0);
    end

    // Memory traffic: M0 writes/reads, then M1 takes over and reads
    use_mem = 1'b1;
    tv_rdy  = 1'b1;
    tv_resp = 1'b0;
    do_reset();
    tick();
    drv0(c_N, 32'h100, 1'b1, 32'h0);
    @(negedge HCLK);
    chk("a0 strans", {30'd0, s.HTRANS}, {30'd0, c_N});
    chk("a0 saddr", s.HADDR, 32'h100);
    chk("a0 m1rdy", {31'd0, m1.HREADY}, 32'd1);
    tick();
    drv0(c_N, 32'h200, 1'b1, 32'hDEAD_BEEF);
    @(negedge HCLK);
    chk("a1 swdata", s.HWDATA, 32'hDEAD_BEEF);
    tick();
    drv0(c_N, 32'h100, 1'b0, 32'hCAFE_F00D);
    tick();
    drv0(c_I, 32'h0, 1'b0, 32'h0);
    drv1(c_N, 32'h200, 1'b0, 32'h0);
    @(negedge HCLK);
    chk("a3 m0rdata", m0.HRDATA, 32'hDEAD_BEEF);
    chk("a3 m1rdy", {31'd0, m1.HREADY}, 32'd0);
    chk("a3 owner", {31'd0, arb_owner}, 32'd0);
    tick();
    @(negedge HCLK);
    chk("a4 owner", {31'd0, arb_owner}, 32'd1);
    chk("a4 saddr", s.HADDR, 32'h200);
    chk("a4 strans", {30'd0, s.HTRANS}, {30'd0, c_N});
    chk("a4 m1rdy", {31'd0, m1.HREADY}, 32'd1);
    tick();
    drv1(c_I, 32'h0, 1'b0, 32'h0);
    @(negedge HCLK);
    chk("a5 m1rdata", m1.HRDATA, 32'hCAFE_F00D);
    chk("a5 m1rdy", {31'd0, m1.HREADY}, 32'd1);

    // Both managers issue NONSEQ every cycle
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      drv0(c_N, 32'h10, 1'b0, c_WD0);
      drv1(c_N, 32'h210, 1'b0, c_WD1);
      @(negedge HCLK);
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("c%0d owner", k), {31'd0, arb_owner}, k % 2);
`else
      chk($sformatf("c%0d owner", k), {31'd0, arb_owner}, 32'd0);
`endif
    end

    // Reset during an M1 data phase with the memory signalling ERROR
    use_mem = 1'b0;
    tv_rdy  = 1'b1;
    tv_resp = 1'b1;
    do_reset();
    tick();
    drv1(c_N, 32'h220, 1'b0, c_WD1);
    @(negedge HCLK);
    chk("r0 owner", {31'd0, arb_owner}, 32'd0);
    chk("r0 m1rdy", {31'd0, m1.HREADY}, 32'd0);
    chk("r0 m1resp", {31'd0, m1.HRESP}, 32'd0);
    tick();
    @(negedge HCLK);
    chk("r1 owner", {31'd0, arb_owner}, 32'd1);
    chk("r1 strans", {30'd0, s.HTRANS}, {30'd0, c_N});
    tick();
    HRESETn = 1'b0;
    drv1(c_N, 32'h224, 1'b0, c_WD1);
    @(negedge HCLK);
    chk("r2 strans", {30'd0, s.HTRANS}, {30'd0, c_I});
    chk("r2 owner", {31'd0, arb_owner}, 32'd0);
    chk("r2 m0rdy", {31'd0, m0.HREADY}, 32'd1);
    chk("r2 m1rdy", {31'd0, m1.HREADY}, 32'd1);
    chk("r2 m0resp", {31'd0, m0.HRESP}, 32'd0);
    chk("r2 m1resp", {31'd0, m1.HRESP}, 32'd0);
    tick();
    HRESETn = 1'b1;
    drv0(c_I, 32'h0, 1'b0, c_WD0);
    drv1(c_I, 32'h0, 1'b0, c_WD1);
    @(negedge HCLK);
    chk("r3 strans", {30'd0, s.HTRANS}, {30'd0, c_I});
    chk("r3 owner", {31'd0, arb_owner}, 32'd0);
    chk("r3 m0rdy", {31'd0, m0.HREADY}, 32'd1);
    chk("r3 m1rdy", {31'd0, m1.HREADY}, 32'd1);
    chk("r3 m0resp", {31'd0, m0.HRESP}, 32'd0);
    chk("r3 m1resp", {31'd0, m1.HRESP}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_dm_arbiter.md
AHB_DM_ARBITER -- requirements
Module: ahb_dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, is the width of the address buses on both manager ports and the subordinate port.
REQ-002 HCLK  in  1  single clock; all state updates on rising edge.
REQ-003 HRESETn  in  1  reset, synchronous and active-low.
REQ-004 M0_HADDR / M1_HADDR  in  ADDR_W  manager address, processor data port (M0) and loader/debug port (M1).
REQ-005 M0_HTRANS / M1_HTRANS  in  2  manager transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 M0_HWRITE / M1_HWRITE  in  1  manager write enable.
REQ-007 M0_HSIZE / M1_HSIZE  in  3  manager transfer size.
REQ-008 M0_HWDATA / M1_HWDATA  in  32  manager write data.
REQ-009 M0_HRDATA / M1_HRDATA  out  32  read data returned to each manager.
REQ-010 M0_HREADY / M1_HREADY  out  1  per-manager ready/stall.
REQ-011 M0_HRESP / M1_HRESP  out  1  per-manager error response.
REQ-012 S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA  out  ADDR_W/2/1/3/32  muxed signals to the data memory.
REQ-013 S_HREADY  out  1  HREADY input of the data memory.
REQ-014 S_HRDATA, S_HREADYOUT, S_HRESP  in  32/1/1  data memory response.
REQ-015 arb_owner  out  1  current address-phase owner (0=M0, 1=M1).

Function
REQ-016 Registers: addr_owner (1b), data_owner (1b), data_active (1b). No other state is permitted beyond the round-robin pointer (REQ-031).
REQ-017 S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE are driven combinationally from the addr_owner manager.
REQ-018 S_HWDATA is driven from the data_owner manager.
REQ-019 S_HREADY equals S_HREADYOUT.
REQ-020 Mx_HRDATA = S_HRDATA for both managers.
REQ-021 Mx_HRESP = S_HRESP when x==data_owner and data_active=1; otherwise 0.
REQ-022 Owner HREADY: Mx_HREADY = S_HREADYOUT when x==addr_owner or (x==data_owner and data_active).
REQ-023 Non-owner HREADY: 0 while its HTRANS is NONSEQ/SEQ (stall holds its address phase stable); 1 otherwise.
REQ-024 Request: manager x requests when Mx_HTRANS is NONSEQ and x is not addr_owner.
REQ-025 Arbitration and data-phase update occur only on edges where S_HREADYOUT=1; on S_HREADYOUT=0 all three registers hold.
REQ-026 data_owner <= addr_owner and data_active <= (S_HTRANS is NONSEQ or SEQ) on each S_HREADYOUT=1 edge.
REQ-027 Burst lock: while the owner drives SEQ or BUSY, addr_owner holds.
REQ-028 Switch: if the owner drives IDLE or NONSEQ and the other manager requests, the arbitration policy (REQ-031) selects next addr_owner.
REQ-029 Parking: with no request, addr_owner holds (park on last owner).
REQ-030 Latency: a stalled request reaches S_HTRANS exactly one cycle after the switching edge; a parked owner issues with zero added latency.
REQ-031 Policy per Configuration: simultaneous owner NONSEQ and other-manager request resolved by that policy; the owner's transfer in the current cycle is always issued.
REQ-032 Two-cycle ERROR response: no re-arbitration on the first (S_HREADYOUT=0) cycle; normal rules on the second.

Reset
REQ-033 While HRESETn=0 at an edge: addr_owner=0, data_owner=0, data_active=0, round-robin pointer=0.
REQ-034 While HRESETn=0: S_HTRANS forced IDLE, Mx_HREADY=1, Mx_HRESP=0, arb_owner=0.
REQ-035 Reset asserted mid-transfer abandons the data phase; no response is delivered to either manager after reset release.

Configuration
REQ-036 Macro ARB_ROUND_ROBIN_EN defined: on a contested switch point the manager that did not own the last completed transfer wins (1-bit pointer); max wait for either manager is one transfer/burst.
REQ-037 ARB_ROUND_ROBIN_EN undefined: fixed priority, M0 always wins contested switch points; M1 may starve; pointer removed.

Verification
REQ-038 M0 NONSEQ write 0x100<=0xDEADBEEF, M1 idle -> issued same cycle, M1_HREADY=1, read-back 0xDEADBEEF.
REQ-039 Owner M0 idle, M1 NONSEQ read 0x200 -> M1_HREADY=0 one cycle, arb_owner=1 next cycle, S_HADDR=0x200, correct data.
REQ-040 M0 4-beat SEQ burst at 0x0, M1 requests at beat 2 -> no switch until burst ends; M1 issued cycle after last beat.
REQ-041 Both issue continuous NONSEQ: RR_EN -> owner alternates every transfer; without macro -> M1 never granted over 20 cycles.
REQ-042 Subordinate inserts 2 wait states during M1 data phase -> registers hold, M0 stalled, arb_owner unchanged.
REQ-043 HRESETn=0 during M1 data phase -> next cycle S_HTRANS=IDLE, arb_owner=0, both HREADY=1, HRESP=0.
